sort_line_feeder: RTL
=====================

Name: sort_line_feeder

Overview:
- Upstream stage of the top-5 sorter pipeline; output drives the sorter's line/enable/last inputs directly.
- Accepts a 32-bit stream of 8-bit elements over a valid/ready handshake, with a per-job element count.
- Packs elements into 256-bit lines (32 lanes) and pads unused lanes with the minimum value.
- Generates the clear pulse, one-cycle enable per line, the last-line flag and the last-line element count.

Parameters:
IN_WIDTH, 32, input word width (4 elements per word)
DATA_WIDTH, 8, element width
LINE_WIDTH, 256, sorter line width (32 lanes)
CNT_WIDTH, 16, element-count width
PAD_VALUE, 8'h80, fill value for unused lanes (sorter minimum)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous active-high reset
start  in  1  job start pulse; sampled only in IDLE
total_num  in  CNT_WIDTH  element count of the job; latched on start
in_data  in  IN_WIDTH  four elements; element 0 in bits [7:0]
in_valid  in  1  in_data valid
in_ready  out  1  feeder accepts the word
sorter_clr  out  1  one-cycle clear to the sorter
sorter_en  out  1  one-cycle line strobe
sorter_in  out  LINE_WIDTH  packed line; lane k in bits [8k+7:8k]
last_sort  out  1  qualifies sorter_en on the final line
last_line_sorter_num  out  5  valid lanes in final line, total_num[4:0]; 0 means a full 32
busy  out  1  high from state CLR through state DONE
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset values: all outputs 0, state IDLE, line buffer all PAD_VALUE, counters 0.
- Reset is asynchronous and may assert in any state; it aborts the job and emits no further strobes.
- States: IDLE -> CLR -> FILL -> DONE -> IDLE.
- IDLE, start=1: latch total_num into tot. Compute words_needed=ceil(tot/4) and lines=ceil(tot/32). Go to CLR.
- CLR: sorter_clr=1 for exactly one cycle. If tot==0, go to DONE with no sorter_en; otherwise go to FILL.
- FILL: in_ready=1 until the last needed word is accepted, then 0. No backpressure from the sorter.
- An accepted word (in_valid&in_ready) fills lanes word_ptr*4 .. word_ptr*4+3 of the line buffer; word_ptr counts 0..7.
- In the last word, bytes at element index >= tot are replaced by PAD_VALUE.
- Line close: happens when word_ptr==7 or the accepted word is the final word.
- On the clock edge ending the close cycle:
  - sorter_in <= merged line (buffer plus current word, lanes not written = PAD_VALUE)
  - sorter_en <= 1, for one cycle
  - line buffer <= all PAD_VALUE
  - word_ptr <= 0
- Line latency is 1 cycle after the closing word is accepted. Back-to-back lines have no bubble; the next word may be accepted in the cycle sorter_en is high.
- Final line: last_sort=1 and last_line_sorter_num=tot[4:0] together with sorter_en. On all other lines both are 0.
- After the final line is emitted, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- sorter_in holds its value between strobes; sorter_en/last_sort/sorter_clr/done are single-cycle pulses.
- Extra in_valid beyond words_needed: not accepted (in_ready=0).
- start outside IDLE: ignored.
- tot up to 2^CNT_WIDTH-1; internal line/word counters are CNT_WIDTH wide.

Optional Feature:
- Macro SORT_LINE_FEEDER_SIGNED_EN.
- Defined: each accepted data byte is XORed with 8'h80 before packing, mapping unsigned input onto the sorter's signed order. Padding stays PAD_VALUE and is not XORed.
- Undefined: bytes pass unchanged.

Test Plan:
- tot=32, 8 words carrying bytes 0..31 back-to-back -> sorter_clr one cycle, then one sorter_en 1 cycle after word 8 with sorter_in lane k = k, last_sort=1, num=0; done next cycle.
- tot=5, words 0x03020100, 0x07060504 -> lanes 0..4 = 0..4; lanes 5..31 = 0x80 (including lanes 5..7 of word 2); num=5; last_sort=1.
- tot=70, 18 words with random in_valid gaps -> 3 sorter_en strobes, only the third with last_sort=1 and num=6; lanes 6..31 of line 3 = 0x80; in_ready=0 after word 18.
- tot=0 -> sorter_clr pulse, done next cycle, zero sorter_en.
- sys_rst asserted mid-FILL after 3 words -> all outputs 0 immediately, no sorter_en. A new start after reset with tot=32 behaves as test 1.
- SORT_LINE_FEEDER_SIGNED_EN defined, tot=4, word 0x00FF7F80 -> lanes 0..3 = 0x00, 0xFF, 0x7F, 0x80; lanes 4..31 = 0x80.

Source files
------------

// File: rtl/sort_line_feeder.sv
// sort_line_feeder: packs a 32-bit element stream into 256-bit sorter lines.
// Four 8-bit elements per input word, 32 lanes per line. Lanes past the job's
// element count are filled with PAD_VALUE (the sorter minimum). The block emits
// a clear pulse per job, a one-cycle strobe per line, and the last-line flag
// with the last-line element count.
// Optional feature: define SORT_LINE_FEEDER_SIGNED_EN to flip the MSB of every
// accepted data byte, so unsigned input follows the sorter's signed order.
module sort_line_feeder #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = 8'h80
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  total_num,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sorter_clr,
  output logic                  sorter_en,
  output logic [LINE_WIDTH-1:0] sorter_in,
  output logic                  last_sort,
  output logic [4:0]            last_line_sorter_num,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned EPW   = IN_WIDTH / DATA_WIDTH;  // elements per word
  localparam int unsigned LANES = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned WPL   = LANES / EPW;            // words per line
  localparam int unsigned PTR_W = $clog2(WPL);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_FILL, S_DONE} state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   tot;
  logic [CNT_WIDTH-1:0]   words_needed;
  logic [CNT_WIDTH-1:0]   word_cnt;
  logic [PTR_W-1:0]       word_ptr;
  logic [LINE_WIDTH-1:0]  line_buf;
  logic [LINE_WIDTH-1:0]  line_merged;
  logic [CNT_WIDTH:0]     words_sum;
  logic                   accept;
  logic                   final_word;
  logic                   line_close;
  logic [DATA_WIDTH-1:0]  elem_byte;
  logic [CNT_WIDTH+1:0]   elem_idx;

  assign words_sum  = {1'b0, total_num} + (CNT_WIDTH+1)'(EPW - 1);
  assign accept     = in_valid & in_ready;
  assign final_word = (word_cnt == words_needed - 1'b1);
  assign line_close = accept & ((word_ptr == PTR_W'(WPL - 1)) | final_word);

  // Line buffer with the current word merged in; bytes past tot become padding.
  always_comb begin
    line_merged = line_buf;
    elem_byte   = '0;
    elem_idx    = '0;
    for (int unsigned j = 0; j < EPW; j++) begin
      elem_idx  = ({2'b00, word_cnt} * (CNT_WIDTH+2)'(EPW)) + (CNT_WIDTH+2)'(j);
      elem_byte = in_data[j*DATA_WIDTH +: DATA_WIDTH];
`ifdef SORT_LINE_FEEDER_SIGNED_EN
      elem_byte = elem_byte ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif
      if (elem_idx >= {2'b00, tot})
        elem_byte = PAD_VALUE;
      line_merged[(int'(word_ptr)*EPW + j)*DATA_WIDTH +: DATA_WIDTH] = elem_byte;
    end
  end

  // Job FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state                <= S_IDLE;
      tot                  <= '0;
      words_needed         <= '0;
      word_cnt             <= '0;
      word_ptr             <= '0;
      line_buf             <= {LANES{PAD_VALUE}};
      in_ready             <= 1'b0;
      sorter_clr           <= 1'b0;
      sorter_en            <= 1'b0;
      sorter_in            <= '0;
      last_sort            <= 1'b0;
      last_line_sorter_num <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      sorter_clr           <= 1'b0;
      sorter_en            <= 1'b0;
      last_sort            <= 1'b0;
      last_line_sorter_num <= '0;
      done                 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tot          <= total_num;
            words_needed <= {1'b0, words_sum[CNT_WIDTH:2]};
            word_cnt     <= '0;
            word_ptr     <= '0;
            busy         <= 1'b1;
            state        <= S_CLR;
          end
        end
        S_CLR: begin
          sorter_clr <= 1'b1;
          if (tot == '0) begin
            state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            word_cnt <= word_cnt + 1'b1;
            if (line_close) begin
              sorter_in <= line_merged;
              sorter_en <= 1'b1;
              line_buf  <= {LANES{PAD_VALUE}};
              word_ptr  <= '0;
              if (final_word) begin
                last_sort            <= 1'b1;
                last_line_sorter_num <= tot[4:0];
                in_ready             <= 1'b0;
                state                <= S_DONE;
              end
            end else begin
              line_buf <= line_merged;
              word_ptr <= word_ptr + 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
